// File: rtl/bisr_output_merge_os.sv
// Output merge stage for the BISR output-stationary systolic array.
// It drains the result matrix from the systolic bottom outputs and captures
// the recompute-unit (RU) results for faulty PEs. It then streams the corrected
// matrix row by row over a valid/ready handshake.
module bisr_output_merge_os #(
    parameter  int ROWS       = 4,
    parameter  int COLS       = 4,
    parameter  int WORD_SIZE  = 16,
    parameter  int NUM_RU     = 4,
    parameter  int RU_TIMEOUT = 64,
    localparam int RC_W       = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int RIDX_W     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        drain_start,
    input  logic [COLS*WORD_SIZE-1:0]   systolic_bottom_out,
    input  logic [NUM_RU-1:0]           ru_expected,
    input  logic [NUM_RU-1:0]           ru_output_valid,
    input  logic [NUM_RU*WORD_SIZE-1:0] rcm_bottom_out,
    input  logic [RC_W*NUM_RU-1:0]      ru_col_mapping,
    input  logic [RC_W*NUM_RU-1:0]      ru_row_mapping,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [RIDX_W-1:0]           out_row_idx,
    output logic [COLS*WORD_SIZE-1:0]   out_row_data,
    output logic                        busy,
    output logic                        done,
    output logic                        ru_timeout_err,
    output logic                        overrun_err
);

    localparam int                   TO_W    = (RU_TIMEOUT > 1) ? $clog2(RU_TIMEOUT) : 1;
    localparam logic [TO_W-1:0]      TO_LAST = TO_W'(RU_TIMEOUT - 1);
    localparam logic [RIDX_W-1:0]    ROW_LAST = RIDX_W'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_WAIT_RU,
        S_EMIT
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [RIDX_W-1:0]          r_beat;
    logic [RIDX_W-1:0]          r_row_cnt;
    logic [TO_W-1:0]            r_to_cnt;
    logic [NUM_RU-1:0]          r_pending;
    logic [NUM_RU-1:0]          r_flag;
    logic                       r_done;
    logic                       r_to_err;
    logic                       r_ovr_err;
    logic [COLS*WORD_SIZE-1:0]  r_buf     [ROWS];
    logic [WORD_SIZE-1:0]       r_ov_data [NUM_RU];
    logic [RC_W-1:0]            r_ov_row  [NUM_RU];
    logic [RC_W-1:0]            r_ov_col  [NUM_RU];

    logic                       w_capture_en;
    logic [NUM_RU-1:0]          w_cap;
    logic [NUM_RU-1:0]          w_pending_nxt;
    logic                       w_beat_last;
    logic                       w_row_last;
    logic                       w_accept;
    logic                       w_to_fire;
    logic [RIDX_W-1:0]          w_wr_row;
    logic [COLS*WORD_SIZE-1:0]  w_row_patched;

    // RU strobes are only honoured while a matrix is being collected.
    assign w_capture_en  = (r_state == S_DRAIN) || (r_state == S_WAIT_RU);
    assign w_cap         = ru_output_valid & r_pending & {NUM_RU{w_capture_en}};
    assign w_pending_nxt = r_pending & ~w_cap;
    assign w_beat_last   = (r_beat == ROW_LAST);
    assign w_row_last    = (r_row_cnt == ROW_LAST);
    assign w_accept      = (r_state == S_EMIT) && out_ready;
    // The bottom row drains first, so beat k lands in row ROWS-1-k.
    assign w_wr_row      = ROW_LAST - r_beat;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic. The timeout error is suppressed if the last RU lands in the final cycle.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (which would infer a latch).
        w_state_nxt = r_state;
        w_to_fire   = 1'b0;
        case (r_state)
            S_IDLE:    if (drain_start) w_state_nxt = S_DRAIN;
            S_DRAIN:   if (w_beat_last) w_state_nxt = (r_pending != '0) ? S_WAIT_RU : S_EMIT;
            S_WAIT_RU: begin
                if (r_pending == '0) begin
                    w_state_nxt = S_EMIT;
                end else if (r_to_cnt == TO_LAST) begin
                    w_state_nxt = S_EMIT;
                    w_to_fire   = (w_pending_nxt != '0);
                end
            end
            S_EMIT:    if (w_accept && w_row_last) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Beat, row and timeout counters, the done pulse and the sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat    <= '0;
            r_row_cnt <= '0;
            r_to_cnt  <= '0;
            r_done    <= 1'b0;
            r_to_err  <= 1'b0;
            r_ovr_err <= 1'b0;
        end else begin
            if (r_state == S_DRAIN)
                r_beat <= w_beat_last ? '0 : r_beat + 1'b1;
            if (w_accept)
                r_row_cnt <= w_row_last ? '0 : r_row_cnt + 1'b1;
            if (r_state == S_WAIT_RU && w_state_nxt == S_WAIT_RU)
                r_to_cnt <= r_to_cnt + 1'b1;
            else
                r_to_cnt <= '0;
            r_done    <= w_accept && w_row_last;
            r_to_err  <= r_to_err | w_to_fire;
            r_ovr_err <= r_ovr_err | (drain_start && r_state != S_IDLE);
        end
    end

    // Matrix buffer written one row per drain beat.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: this storage is reset on purpose so an aborted matrix can never leak into a later one.
        if (rst) begin
            for (int r = 0; r < ROWS; r++) r_buf[r] <= '0;
        end else if (r_state == S_DRAIN) begin
            r_buf[w_wr_row] <= systolic_bottom_out;
        end
    end

    // RU capture: pending mask, override flags and tagged override slots.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
            r_flag    <= '0;
            for (int i = 0; i < NUM_RU; i++) begin
                r_ov_data[i] <= '0;
                r_ov_row[i]  <= '0;
                r_ov_col[i]  <= '0;
            end
        end else if (r_state == S_IDLE && drain_start) begin
            r_pending <= ru_expected;
            r_flag    <= '0;
        end else if (w_capture_en) begin
            r_pending <= w_pending_nxt;
            r_flag    <= r_flag | w_cap;
            for (int i = 0; i < NUM_RU; i++) begin
                if (w_cap[i]) begin
                    r_ov_data[i] <= rcm_bottom_out[i*WORD_SIZE +: WORD_SIZE];
                    r_ov_row[i]  <= ru_row_mapping[i*RC_W +: RC_W];
                    r_ov_col[i]  <= ru_col_mapping[i*RC_W +: RC_W];
                end
            end
        end
    end

    // Patch mux: later (higher-index) slots overwrite earlier ones on a shared coordinate.
    always_comb begin
        w_row_patched = r_buf[r_row_cnt];
        for (int i = 0; i < NUM_RU; i++) begin
            for (int c = 0; c < COLS; c++) begin
                if (r_flag[i] && r_ov_row[i] == RC_W'(r_row_cnt) && r_ov_col[i] == RC_W'(c))
                    w_row_patched[c*WORD_SIZE +: WORD_SIZE] = r_ov_data[i];
            end
        end
    end

    assign out_valid      = (r_state == S_EMIT);
    assign out_row_idx    = r_row_cnt;
    assign out_row_data   = out_valid ? w_row_patched : '0;
    assign busy           = (r_state != S_IDLE);
    assign done           = r_done;
    assign ru_timeout_err = r_to_err;
    assign overrun_err    = r_ovr_err;

endmodule

// File: tb/tb_bisr_output_merge_os.sv
// Self-checking bench for bisr_output_merge_os (4x4, 16-bit words, 4 RUs, RU_TIMEOUT=8).
// Expected rows go into a scoreboard queue; a negedge monitor compares every presented row.
module tb_bisr_output_merge_os;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int WS   = 16;
    localparam int NRU  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            drain_start = 1'b0;
    logic [63:0]     systolic_bottom_out = '0;
    logic [3:0]      ru_expected = '0;
    logic [3:0]      ru_output_valid = '0;
    logic [63:0]     rcm_bottom_out = '0;
    logic [7:0]      ru_col_mapping = '0;
    logic [7:0]      ru_row_mapping = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [1:0]      out_row_idx;
    logic [63:0]     out_row_data;
    logic            busy;
    logic            done;
    logic            ru_timeout_err;
    logic            overrun_err;

    typedef struct {
        logic [1:0]  idx;
        logic [63:0] data;
    } row_t;

    row_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    bisr_output_merge_os #(
        .ROWS(ROWS), .COLS(COLS), .WORD_SIZE(WS), .NUM_RU(NRU), .RU_TIMEOUT(8)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .drain_start         (drain_start),
        .systolic_bottom_out (systolic_bottom_out),
        .ru_expected         (ru_expected),
        .ru_output_valid     (ru_output_valid),
        .rcm_bottom_out      (rcm_bottom_out),
        .ru_col_mapping      (ru_col_mapping),
        .ru_row_mapping      (ru_row_mapping),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_row_idx         (out_row_idx),
        .out_row_data        (out_row_data),
        .busy                (busy),
        .done                (done),
        .ru_timeout_err      (ru_timeout_err),
        .overrun_err         (overrun_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Systolic word for matrix 'tag', row r, column c: tag*0x100 + r*0x10 + c.
    function automatic logic [63:0] sys_row(input int tag, input int r);
        logic [63:0] v;
        for (int c = 0; c < COLS; c++) v[c*WS +: WS] = 16'(tag*256 + r*16 + c);
        return v;
    endfunction

    task automatic push_row(input int r, input logic [63:0] d);
        row_t e;
        e.idx  = 2'(r);
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic push_plain(input int tag);
        for (int r = 0; r < ROWS; r++) push_row(r, sys_row(tag, r));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // drain_start in cycle 0, beats in cycles 1..4; optional RU strobe during one beat. Returns in cycle 5.
    task automatic drive_drain(input int tag, input int strobe_beat, input logic [3:0] strobe_mask);
        cyc = 0;
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        for (int k = 0; k < ROWS; k++) begin
            systolic_bottom_out = sys_row(tag, ROWS - 1 - k);
            ru_output_valid     = (k == strobe_beat) ? strobe_mask : 4'b0000;
            tick();
        end
        systolic_bottom_out = '0;
        ru_output_valid     = '0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        check({name, "_done"}, 64'(done), 64'd1);
        check({name, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
    endtask

    task automatic check_quiet(input string name);
        check({name, "_valid"}, 64'(out_valid), 64'd0);
        check({name, "_idx"},   64'(out_row_idx), 64'd0);
        check({name, "_data"},  out_row_data, 64'd0);
        check({name, "_busy"},  64'(busy), 64'd0);
        check({name, "_done"},  64'(done), 64'd0);
        check({name, "_to_err"}, 64'(ru_timeout_err), 64'd0);
        check({name, "_ovr_err"}, 64'(overrun_err), 64'd0);
    endtask

    // Scoreboard monitor: every presented row is compared against the queue head, popped on acceptance.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_row: got idx %0d data 0x%0h, queue empty", out_row_idx, out_row_data);
                end else begin
                    check("row_idx", 64'(out_row_idx), 64'(sb_q[0].idx));
                    check("row_data", out_row_data, sb_q[0].data);
                    if (out_ready) void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [63:0] d;
        logic [15:0] rdy_pat;

        // Reset state.
        tick();
        tick();
        check_quiet("reset");
        rst = 1'b0;
        tick();

        // T1: no RUs, ready tied high; first row at cycle 5, done at cycle 9.
        push_plain(0);
        drive_drain(0, -1, 4'b0000);
        check("t1_first_valid_c5", 64'(out_valid), 64'd1);
        wait_done("t1");
        check("t1_done_cycle", 64'(cyc), 64'd9);
        tick();

        // T2: RU0 -> (2,1)=0xBEEF strobed during WAIT_RU.
        ru_expected    = 4'b0001;
        ru_row_mapping = 8'h02;
        ru_col_mapping = 8'h01;
        rcm_bottom_out = 64'h7777_6666_5555_BEEF;
        for (int r = 0; r < ROWS; r++) begin
            d = sys_row(1, r);
            if (r == 2) d[1*WS +: WS] = 16'hBEEF;
            push_row(r, d);
        end
        drive_drain(1, -1, 4'b0000);
        check("t2_wait_busy", 64'(busy), 64'd1);
        check("t2_wait_no_valid", 64'(out_valid), 64'd0);
        tick();
        tick();
        check("t2_still_waiting_c7", 64'(out_valid), 64'd0);
        ru_output_valid = 4'b0001;
        tick();
        ru_output_valid = 4'b0000;
        wait_done("t2");
        check("t2_no_timeout", 64'(ru_timeout_err), 64'd0);
        tick();

        // T3: RU1,RU3 -> (0,0) same cycle; RU0 strobes but is not expected.
        ru_expected    = 4'b1010;
        ru_row_mapping = 8'h31;   // RU3=0 RU2=3 RU1=0 RU0=1
        ru_col_mapping = 8'h31;
        rcm_bottom_out = 64'h3333_2222_1111_DEAD;
        for (int r = 0; r < ROWS; r++) begin
            d = sys_row(2, r);
            if (r == 0) d[0 +: WS] = 16'h3333;
            push_row(r, d);
        end
        drive_drain(2, 1, 4'b1011);
        check("t3_emit_direct", 64'(out_valid), 64'd1);
        wait_done("t3");
        tick();

        // T4: RU1 expected but never strobes; timeout after 8 WAIT_RU cycles (5..12).
        ru_expected    = 4'b0010;
        ru_row_mapping = 8'h0C;
        ru_col_mapping = 8'h08;
        rcm_bottom_out = 64'h0000_0000_5151_0000;
        push_plain(3);
        drive_drain(3, -1, 4'b0000);
        while (cyc < 12) tick();
        check("t4_no_err_c12", 64'(ru_timeout_err), 64'd0);
        check("t4_no_valid_c12", 64'(out_valid), 64'd0);
        tick();
        check("t4_err_c13", 64'(ru_timeout_err), 64'd1);
        check("t4_valid_c13", 64'(out_valid), 64'd1);
        wait_done("t4");
        tick();

        // T5: ready stalls during EMIT plus a drain_start while busy.
        ru_expected = 4'b0000;
        rdy_pat     = 16'b1101_0110_1010_0100;
        push_plain(5);
        drive_drain(5, -1, 4'b0000);
        check("t5_ovr_before", 64'(overrun_err), 64'd0);
        for (int n = 0; n < 100 && !done; n++) begin
            out_ready   = rdy_pat[n % 16];
            drain_start = (n == 3);
            tick();
        end
        drain_start = 1'b0;
        out_ready   = 1'b1;
        check("t5_done", 64'(done), 64'd1);
        check("t5_sb_empty", 64'(sb_q.size()), 64'd0);
        check("t5_ovr_after", 64'(overrun_err), 64'd1);
        tick();
        check("t5_overrun_ignored", 64'(busy), 64'd0);

        // T6: reset at DRAIN beat 2 after RU0 -> (0,0)=0xAAAA was captured; fresh drain must be clean.
        ru_expected    = 4'b0001;
        ru_row_mapping = 8'h00;
        ru_col_mapping = 8'h00;
        rcm_bottom_out = 64'h0000_0000_0000_AAAA;
        cyc = 0;
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        systolic_bottom_out = sys_row(6, 3);
        ru_output_valid     = 4'b0001;
        tick();
        ru_output_valid     = 4'b0000;
        systolic_bottom_out = sys_row(6, 2);
        tick();
        systolic_bottom_out = sys_row(6, 1);
        check("t6_busy_before_rst", 64'(busy), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_quiet("t6_rst");
        systolic_bottom_out = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        ru_expected = 4'b0000;
        push_plain(7);
        drive_drain(7, -1, 4'b0000);
        wait_done("t6");
        tick();

        check("final_sb_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
